// File: rtl/div_array_pkg.sv
// Shared types for the iterative divider array: op encodings, unit states, bundles.
package div_array_pkg;

    typedef enum logic [7:0] {
        F_DIV   = 8'h01, F_DIVU  = 8'h02, F_REM  = 8'h04, F_REMU  = 8'h08,
        F_DIVW  = 8'h10, F_DIVUW = 8'h20, F_REMW = 8'h40, F_REMUW = 8'h80
    } div_funct_t;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

    localparam logic [7:0] DIV_W_MASK = 8'hF0;
    localparam logic [7:0] DIV_S_MASK = 8'h55;
    localparam logic [7:0] DIV_R_MASK = 8'hCC;

    typedef struct packed {
        logic [15:0] opid;
        logic [4:0]  fu;
        div_funct_t  funct;
        logic [63:0] base;
        logic [7:0]  delta;
        logic [6:0]  prda;
        logic [63:0] op0;
        logic [63:0] op1;
    } reg_bundle_t;

    typedef struct packed {
        logic [15:0] opid;
        logic [63:0] npc;
        logic [6:0]  prda;
        logic [63:0] prdv;
        logic [3:0]  exc;
    } exe_bundle_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/div_unit.sv
// One radix-2 divider: magnitude long division with leading-one skip, then sign fix.
module div_unit
    import div_array_pkg::*;
#(
    parameter int xlen = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        start_i,
    input  reg_bundle_t in_i,
    input  logic        hit_i,
    input  logic [63:0] hit_val_i,
    input  logic        ack_i,
    output logic        busy_o,
    output logic        done_o,
    output exe_bundle_t out_o
);

    div_state_t  state_q, state_d;
    logic [15:0] opid_q, opid_d;
    logic [63:0] npc_q, npc_d, res_q, res_d, rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [6:0]  prda_q, prda_d;
    logic [5:0]  c_q, c_d;
    logic        negq_q, negq_d, negr_q, negr_d, isrem_q, isrem_d, isw_q, isw_d;

    logic        isw, sgn, isrem, narrow, sa, sb, ovf, dz, fits;
    logic [63:0] a, b, ma, mb, rem_n, q_fix, r_fix;
    logic [127:0] shd;
    logic        unused_fu;

    assign unused_fu = ^in_i.fu;

    function automatic logic [5:0] msb(input logic [63:0] v);
        msb = '0;
        for (int i = 0; i < 64; i++) if (v[i]) msb = 6'(i);
    endfunction

    function automatic logic [63:0] fin(input logic [63:0] v, input logic w);
        if (w) return sext32(v[31:0]);
        else if (xlen == 32) return {32'b0, v[31:0]};
        else return v;
    endfunction

    always_comb begin
        isw    = |(in_i.funct & DIV_W_MASK);
        sgn    = |(in_i.funct & DIV_S_MASK);
        isrem  = |(in_i.funct & DIV_R_MASK);
        narrow = isw || (xlen == 32);
        a      = in_i.op0;
        b      = in_i.op1;
        if (narrow) begin
            a = sgn ? sext32(in_i.op0[31:0]) : {32'b0, in_i.op0[31:0]};
            b = sgn ? sext32(in_i.op1[31:0]) : {32'b0, in_i.op1[31:0]};
        end
        sa  = sgn & a[63];
        sb  = sgn & b[63];
        ma  = sa ? -a : a;
        mb  = sb ? -b : b;
        ovf = sgn && (&b) && (a == (narrow ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        dz  = (b == '0);
    end

    // Divisor aligned to bit c; 128 bits so the shift never loses high bits.
    always_comb begin
        shd   = {64'b0, dvs_q} << c_q;
        fits  = shd <= {64'b0, rem_q};
        rem_n = fits ? rem_q - shd[63:0] : rem_q;
        q_fix = negq_q ? -quo_q : quo_q;
        r_fix = negr_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d = state_q;
        opid_d  = opid_q;
        npc_d   = npc_q;
        prda_d  = prda_q;
        res_d   = res_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        c_d     = c_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        isrem_d = isrem_q;
        isw_d   = isw_q;
        case (state_q)
            IDLE: if (start_i) begin
                opid_d  = in_i.opid;
                npc_d   = in_i.base + {56'b0, in_i.delta};
                prda_d  = in_i.prda;
                isw_d   = isw;
                isrem_d = isrem;
                negq_d  = sa ^ sb;
                negr_d  = sa;
                rem_d   = ma;
                dvs_d   = mb;
                quo_d   = '0;
                c_d     = msb(ma);
                if (hit_i) begin
                    res_d   = hit_val_i;
                    state_d = DONE;
                end else if (dz) begin
                    res_d   = fin(isrem ? a : '1, isw);
                    state_d = DONE;
                end else if (ovf) begin
                    res_d   = fin(isrem ? '0 : a, isw);
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: if (rem_q == '0) begin
                state_d = FIX;
            end else begin
                rem_d = rem_n;
                quo_d = quo_q | (64'(fits) << c_q);
                if (c_q == '0) state_d = FIX;
                else c_d = (msb(rem_n) < c_q - 6'd1) ? msb(rem_n) : c_q - 6'd1;
            end
            FIX: begin
                res_d   = fin(isrem_q ? r_fix : q_fix, isw_q);
                state_d = DONE;
            end
            DONE: if (ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) state_q <= IDLE;
        else                state_q <= state_d;
        opid_q  <= opid_d;
        npc_q   <= npc_d;
        prda_q  <= prda_d;
        res_q   <= res_d;
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dvs_q   <= dvs_d;
        c_q     <= c_d;
        negq_q  <= negq_d;
        negr_q  <= negr_d;
        isrem_q <= isrem_d;
        isw_q   <= isw_d;
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DONE);
        out_o  = '0;
        if (done_o) begin
            out_o.opid = opid_q;
            out_o.npc  = npc_q;
            out_o.prda = prda_q;
            out_o.prdv = res_q;
        end
    end

endmodule

// File: rtl/div_array.sv
// Divider array: in-order request buffer, dispatch to nunit div_units, compacted responses.
// DIV_MEMO_EN adds a one-entry result memo that short-circuits repeated operations.
module div_array
    import div_array_pkg::*;
#(
    parameter int iwd   = 4,
    parameter int ewd   = 4,
    parameter int eqsz  = 8,
    parameter int nunit = 2,
    parameter int xlen  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    output logic                          ready_o,
    input  reg_bundle_t [iwd-1:0]         req_i,
    input  logic        [ewd-1:0]         claim_i,
    output exe_bundle_t [ewd-1:0]         resp_o
);

    localparam int QW = $clog2(eqsz);
    localparam int CW = QW + 1;

    reg_bundle_t      buf_q [eqsz];
    reg_bundle_t      buf_d [eqsz];
    reg_bundle_t      head;
    logic [QW-1:0]    head_q, tail_q;
    logic [CW-1:0]    cnt_q, nacc;
    logic             disp, hit;
    logic [63:0]      hit_val;
    logic [nunit-1:0] start, busy, done, ack;
    exe_bundle_t      uout [nunit];
    int               k;

    // DIV lanes are packed contiguously at the tail in lane order.
    always_comb begin
        buf_d = buf_q;
        nacc  = '0;
        for (int j = 0; j < iwd; j++) begin
            if (req_i[j].opid[15] && req_i[j].fu[4]) begin
                buf_d[tail_q + nacc[QW-1:0]] = req_i[j];
                nacc = nacc + CW'(1);
            end
        end
    end

    always_comb begin
        head  = buf_q[head_q];
        disp  = 1'b0;
        start = '0;
        if (cnt_q != '0 && !flush_i) begin
            for (int u = 0; u < nunit; u++) begin
                if (!busy[u] && !disp) begin
                    start[u] = 1'b1;
                    disp     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_q + QW'(disp);
            tail_q <= tail_q + nacc[QW-1:0];
            cnt_q  <= cnt_q + nacc - CW'(disp);
        end
        buf_q <= buf_d;
    end

    assign ready_o = (cnt_q <= CW'(eqsz - iwd));

`ifdef DIV_MEMO_EN
    div_funct_t       mf_q;
    logic [63:0]      mop0_q, mop1_q, mres_q;
    logic             mv_q;
    div_funct_t       kf_q [nunit];
    logic [63:0]      kop0_q [nunit];
    logic [63:0]      kop1_q [nunit];
    logic [nunit-1:0] done_prev_q;

    assign hit     = mv_q && head.funct == mf_q && head.op0 == mop0_q && head.op1 == mop1_q;
    assign hit_val = mres_q;

    // Each unit remembers its operands so the memo can be filled when it first shows DONE.
    always_ff @(posedge clk) begin
        done_prev_q <= done;
        for (int u = 0; u < nunit; u++) begin
            if (start[u]) begin
                kf_q[u]   <= head.funct;
                kop0_q[u] <= head.op0;
                kop1_q[u] <= head.op1;
            end
        end
        if (rst || flush_i) begin
            mv_q <= 1'b0;
        end else begin
            for (int u = 0; u < nunit; u++) begin
                if (done[u] && !done_prev_q[u]) begin
                    mv_q   <= 1'b1;
                    mf_q   <= kf_q[u];
                    mop0_q <= kop0_q[u];
                    mop1_q <= kop1_q[u];
                    mres_q <= uout[u].prdv;
                end
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_val = '0;
`endif

    for (genvar u = 0; u < nunit; u++) begin : g_unit
        div_unit #(.xlen(xlen)) u_unit (
            .clk       (clk),
            .rst       (rst),
            .flush_i   (flush_i),
            .start_i   (start[u]),
            .in_i      (head),
            .hit_i     (hit),
            .hit_val_i (hit_val),
            .ack_i     (ack[u]),
            .busy_o    (busy[u]),
            .done_o    (done[u]),
            .out_o     (uout[u])
        );
    end

    always_comb begin
        resp_o = '0;
        ack    = '0;
        k      = 0;
        for (int u = 0; u < nunit; u++) begin
            if (done[u]) begin
                resp_o[k] = uout[u];
                ack[u]    = claim_i[k];
                k         = k + 1;
            end
        end
    end

endmodule

// File: tb/tb_div_array.sv
// Directed bench for div_array: arithmetic vectors, special cases, buffering, flush, memo.
module tb_div_array;
    import div_array_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush_i;
    logic                   ready_o;
    reg_bundle_t [3:0]      req_i;
    logic        [3:0]      claim_i;
    exe_bundle_t [3:0]      resp_o;

    int n_chk = 0;
    int n_err = 0;
    int unsigned nid = 0;
    int lat, lat2;
    logic bad;

    div_array dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .ready_o (ready_o),
        .req_i   (req_i),
        .claim_i (claim_i),
        .resp_o  (resp_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic reg_bundle_t mk(input logic [15:0] id, input div_funct_t f,
                                       input logic [63:0] a, input logic [63:0] b);
        reg_bundle_t r;
        r       = '0;
        r.opid  = id;
        r.fu    = 5'h10;
        r.funct = f;
        r.base  = 64'h1000 + {48'b0, id};
        r.delta = 8'h4;
        r.prda  = id[6:0];
        r.op0   = a;
        r.op1   = b;
        return r;
    endfunction

    function automatic logic [15:0] new_id();
        nid++;
        return 16'h8000 | 16'(nid);
    endfunction

    task automatic run_op(input string tag, input div_funct_t f, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, output int l);
        logic [15:0] id;
        id = new_id();
        req_i    = '0;
        req_i[0] = mk(id, f, a, b);
        tick;
        req_i = '0;
        l = 0;
        while (resp_o[0].opid == 16'h0 && l < 200) begin
            tick;
            l++;
        end
        chk({tag, "_prdv"}, resp_o[0].prdv, exp);
        chk({tag, "_opid"}, {48'b0, resp_o[0].opid}, {48'b0, id});
        chk({tag, "_npc"}, resp_o[0].npc, 64'h1000 + {48'b0, id} + 64'h4);
        claim_i = 4'b0001;
        tick;
        claim_i = '0;
        chk({tag, "_retired"}, {48'b0, resp_o[0].opid}, 64'h0);
    endtask

    initial begin
        rst     = 1'b1;
        flush_i = 1'b0;
        req_i   = '0;
        claim_i = '1;
        tick;
        rst     = 1'b0;
        claim_i = '0;
        chk("rst_ready", {63'b0, ready_o}, 64'h1);
        chk("rst_resp", {63'b0, resp_o == '0}, 64'h1);

        run_op("div_s", F_DIV, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, lat);
        chk("div_s_lat", {63'b0, lat > 1 && lat <= 66}, 64'h1);
        run_op("rem_s", F_REM, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat);
        run_op("divu", F_DIVU, 64'd100, 64'd7, 64'd14, lat);
        run_op("remuw", F_REMUW, 64'hFFFF_FFFF_0000_0007, 64'd3, 64'd1, lat);
        chk("remuw_lat", {63'b0, lat <= 34}, 64'h1);
        run_op("div_neg", F_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, lat);
        run_op("rem_neg", F_REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, lat);
        run_op("divuw_sx", F_DIVUW, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, lat);
        run_op("divu_zero", F_DIVU, 64'd0, 64'd5, 64'd0, lat);
        run_op("ovf_div", F_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, lat);
        chk("ovf_div_lat", 64'(lat), 64'd1);
        run_op("ovf_rem", F_REM, 64'h8000_0000_0000_0000, '1, 64'd0, lat);
        chk("ovf_rem_lat", 64'(lat), 64'd1);
        run_op("divw_dz", F_DIVW, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        chk("divw_dz_lat", 64'(lat), 64'd1);
        run_op("remw_dz", F_REMW, 64'd5, 64'd0, 64'd5, lat);
        chk("remw_dz_lat", 64'(lat), 64'd1);

        // Four ops in one cycle against two units
        req_i[0] = mk(16'h8011, F_DIVU, 64'd1000, 64'd10);
        req_i[1] = mk(16'h8012, F_DIVU, 64'd2000, 64'd10);
        req_i[2] = mk(16'h8013, F_DIVU, 64'd3000, 64'd10);
        req_i[3] = mk(16'h8014, F_DIVU, 64'd4000, 64'd10);
        tick;
        req_i = '0;
        lat = 0;
        while (resp_o[1].opid == 16'h0 && lat < 200) begin
            tick;
            lat++;
        end
        chk("q4_r0_id", {48'b0, resp_o[0].opid}, 64'h8011);
        chk("q4_r1_id", {48'b0, resp_o[1].opid}, 64'h8012);
        chk("q4_r0_v", resp_o[0].prdv, 64'd100);
        chk("q4_r1_v", resp_o[1].prdv, 64'd200);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (resp_o[0].opid != 16'h8011 || resp_o[1].opid != 16'h8012 ||
                resp_o[0].prdv != 64'd100 || resp_o[2].opid != 16'h0 || !ready_o) bad = 1'b1;
        end
        chk("q4_hold", {63'b0, bad}, 64'h0);
        claim_i = 4'b0001;
        tick;
        claim_i = '0;
        chk("q4_compact", {48'b0, resp_o[0].opid}, 64'h8012);
        lat = 0;
        while (resp_o[1].opid == 16'h0 && lat < 200) begin
            tick;
            lat++;
        end
        chk("q4_u0_third", {48'b0, resp_o[0].opid}, 64'h8013);
        chk("q4_u0_v", resp_o[0].prdv, 64'd300);
        chk("q4_u1_kept", {48'b0, resp_o[1].opid}, 64'h8012);
        claim_i = 4'b1000;
        tick;
        claim_i = '0;
        chk("q4_inv_claim", {32'b0, resp_o[0].opid, resp_o[1].opid}, 64'h8013_8012);
        claim_i = 4'b0011;
        tick;
        claim_i = '0;
        lat = 0;
        while (resp_o[0].opid == 16'h0 && lat < 200) begin
            tick;
            lat++;
        end
        chk("q4_fourth_id", {48'b0, resp_o[0].opid}, 64'h8014);
        chk("q4_fourth_v", resp_o[0].prdv, 64'd400);
        claim_i = 4'b0001;
        tick;
        claim_i = '0;

        // Flush while a result is fresh in DONE and being claimed
        req_i[0] = mk(16'h8021, F_DIVW, 64'd5, 64'd0);
        req_i[1] = mk(16'h8022, F_DIVU, '1, 64'd3);
        req_i[2] = mk(16'h8023, F_DIVU, 64'd100, 64'd7);
        tick;
        req_i = '0;
        tick;
        chk("fl_pre", {48'b0, resp_o[0].opid}, 64'h8021);
        flush_i = 1'b1;
        claim_i = 4'b0001;
        tick;
        flush_i = 1'b0;
        claim_i = '0;
        chk("fl_resp", {63'b0, resp_o == '0}, 64'h1);
        chk("fl_ready", {63'b0, ready_o}, 64'h1);
        bad = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick;
            if (resp_o != '0) bad = 1'b1;
        end
        chk("fl_quiet", {63'b0, bad}, 64'h0);
        run_op("post_fl", F_DIVU, 64'd100, 64'd7, 64'd14, lat);

        // Memo: identical op twice, then same operands with a different funct
        run_op("memo_a", F_DIV, 64'd12345, 64'd67, 64'd184, lat);
        run_op("memo_b", F_DIV, 64'd12345, 64'd67, 64'd184, lat2);
`ifdef DIV_MEMO_EN
        chk("memo_lat", 64'(lat2), 64'd1);
`else
        chk("memo_lat", {63'b0, lat2 > 1}, 64'h1);
`endif
        run_op("memo_rem", F_REM, 64'd12345, 64'd67, 64'd17, lat);
        chk("memo_rem_lat", {63'b0, lat > 1}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
